// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute side bundle of the branch resolve queue.
// Handshake: a push transfers on a rising edge where push_valid && push_ready,
// unless the same edge carries a mispredict kill, which drops it; push_ready
// depends only on occupancy and never on push_valid. resolve_valid has no
// ready: it always targets the oldest entry and is ignored (flagged) if empty.
// upd_valid and flush are one-cycle registered strobes with no back-pressure.
interface branch_resolve_queue_if #(
   parameter int INDEX_BITS = 10
);
   logic                  push_valid;
   logic                  push_ready;
   logic [31:0]           push_pc;
   logic                  push_taken;
   logic [31:0]           push_target;
   logic [1:0]            push_ctr;
   logic                  resolve_valid;
   logic                  resolve_taken;
   logic [31:0]           resolve_target;
   logic                  upd_valid;
   logic [INDEX_BITS-1:0] upd_index;
   logic [1:0]            upd_ctr;
   logic                  flush;
   logic [31:0]           redirect_pc;

   modport master (
      output push_valid, push_pc, push_taken, push_target, push_ctr,
      output resolve_valid, resolve_taken, resolve_target,
      input  push_ready, upd_valid, upd_index, upd_ctr, flush, redirect_pc
   );

   modport slave (
      input  push_valid, push_pc, push_taken, push_target, push_ctr,
      input  resolve_valid, resolve_taken, resolve_target,
      output push_ready, upd_valid, upd_index, upd_ctr, flush, redirect_pc
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. The head is resolved by execute; the
// block produces the saturated history-counter write-back and, on a
// mispredict, a one-cycle flush with the corrected fetch PC while discarding
// every younger entry.
module branch_resolve_queue #(
   parameter int DEPTH      = 4,
   parameter int INDEX_BITS = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   branch_resolve_queue_if.slave    bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underflow_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0] pc_mem     [DEPTH];
   logic        taken_mem  [DEPTH];
   logic [31:0] target_mem [DEPTH];
   logic [1:0]  ctr_mem    [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   logic        full;
   logic        empty;
   logic        resolve_fire;
   logic        kill;
   logic        push_fire;
   logic [31:0] h_pc;
   logic        h_taken;
   logic [31:0] h_target;
   logic [1:0]  h_ctr;
   logic [1:0]  new_ctr;
   logic [31:0] redirect_next;

   // Head decode, mispredict detection and saturating counter arithmetic.
   always_comb begin
      full          = (count == CW'(DEPTH));
      empty         = (count == '0);
      h_pc          = pc_mem[rd_ptr];
      h_taken       = taken_mem[rd_ptr];
      h_target      = target_mem[rd_ptr];
      h_ctr         = ctr_mem[rd_ptr];
      resolve_fire  = bus.resolve_valid && !empty;
      // Target only matters when the branch was actually taken.
      kill          = resolve_fire &&
                      ((h_taken != bus.resolve_taken) ||
                       (bus.resolve_taken && (h_target != bus.resolve_target)));
      // A kill empties the queue at this edge, so a same-cycle push is lost.
      push_fire     = bus.push_valid && !full && !kill;
      new_ctr       = h_ctr;
      if (bus.resolve_taken) begin
         if (h_ctr != 2'd3) new_ctr = h_ctr + 2'd1;
      end else begin
         if (h_ctr != 2'd0) new_ctr = h_ctr - 2'd1;
      end
      redirect_next = bus.resolve_taken ? bus.resolve_target : (h_pc + 32'd4);
   end

   assign bus.push_ready = !full;

   // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         pc_mem[wr_ptr]     <= bus.push_pc;
         taken_mem[wr_ptr]  <= bus.push_taken;
         target_mem[wr_ptr] <= bus.push_target;
         ctr_mem[wr_ptr]    <= bus.push_ctr;
      end
   end

   // Pointers and occupancy; a kill snaps the read side onto the write side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (kill) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push_fire)    wr_ptr <= wr_ptr + 1'b1;
         if (resolve_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({push_fire, resolve_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered history-table write-back, flush pulse and underflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.upd_valid   <= 1'b0;
         bus.upd_index   <= '0;
         bus.upd_ctr     <= 2'd0;
         bus.flush       <= 1'b0;
         bus.redirect_pc <= 32'd0;
         underflow_err   <= 1'b0;
      end else begin
         bus.upd_valid <= resolve_fire;
         bus.flush     <= kill;
         if (resolve_fire) begin
            bus.upd_index <= h_pc[INDEX_BITS+1:2];
            bus.upd_ctr   <= new_ctr;
         end
         if (kill) bus.redirect_pc <= redirect_next;
         if (bus.resolve_valid && empty) underflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a reference queue model
// predicts each cycle, and expected write-backs go through a scoreboard.
module tb_branch_resolve_queue;
   localparam int DEPTH      = 4;
   localparam int INDEX_BITS = 10;
   localparam int CW         = $clog2(DEPTH) + 1;
   localparam int W          = 1 + INDEX_BITS + 2 + 32;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [1:0]  ctr;
   } entry_t;

   logic          clk;
   logic          rst;
   logic [CW-1:0] count;
   logic          underflow_err;

   branch_resolve_queue_if #(.INDEX_BITS(INDEX_BITS)) bus();

   branch_resolve_queue #(.DEPTH(DEPTH), .INDEX_BITS(INDEX_BITS)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .count         (count),
      .underflow_err (underflow_err)
   );

   int tests = 0;
   int fails = 0;

   // Reference state.
   entry_t          mdl[$];
   logic [W-1:0]    exp_q[$];
   logic            exp_upd      = 1'b0;
   logic            exp_flush    = 1'b0;
   logic [31:0]     exp_redirect = 32'd0;
   logic            exp_uf       = 1'b0;

   // Clock and power-on reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial rst = 1'b1;

   function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic t);
      int v;
      v = t ? int'(c) + 1 : int'(c) - 1;
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   // Scoreboard: compare each write-back strobe against the oldest expectation.
   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      if (!rst && bus.upd_valid) begin
         tests++;
         got = {bus.flush, bus.upd_index, bus.upd_ctr, bus.redirect_pc};
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_upd: got %h, required no strobe", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL sb_upd: got %h, required %h", got, e);
            end
         end
      end
   end

   // Drive one cycle of push/resolve, predict the outcome, check after the edge.
   task automatic drive_cycle(input logic pv, input logic [31:0] pc, input logic pt,
                              input logic [31:0] ptg, input logic [1:0] pctr,
                              input logic rv, input logic rt, input logic [31:0] rtg);
      entry_t h;
      entry_t n;
      logic   kill;
      int     occ;
      bus.push_valid     = pv;
      bus.push_pc        = pc;
      bus.push_taken     = pt;
      bus.push_target    = ptg;
      bus.push_ctr       = pctr;
      bus.resolve_valid  = rv;
      bus.resolve_taken  = rt;
      bus.resolve_target = rtg;
      occ  = mdl.size();
      tests++;
      if (bus.push_ready !== (occ < DEPTH)) begin
         fails++;
         $display("FAIL push_ready: got %b, required %b", bus.push_ready, (occ < DEPTH));
      end
      kill    = 1'b0;
      exp_upd = 1'b0;
      if (rv) begin
         if (occ == 0) begin
            exp_uf = 1'b1;
         end else begin
            h    = mdl.pop_front();
            kill = (h.taken != rt) || (rt && (h.target != rtg));
            if (kill) exp_redirect = rt ? rtg : h.pc + 32'd4;
            exp_q.push_back({kill, h.pc[INDEX_BITS+1:2], sat_ctr(h.ctr, rt), exp_redirect});
            exp_upd = 1'b1;
         end
      end
      if (kill) begin
         mdl.delete();
      end else if (pv && occ < DEPTH) begin
         n.pc = pc; n.taken = pt; n.target = ptg; n.ctr = pctr;
         mdl.push_back(n);
      end
      exp_flush = kill;
      @(posedge clk); #1;
      tests++;
      if (bus.upd_valid !== exp_upd) begin
         fails++;
         $display("FAIL upd_valid: got %b, required %b", bus.upd_valid, exp_upd);
      end
      tests++;
      if (bus.flush !== exp_flush) begin
         fails++;
         $display("FAIL flush: got %b, required %b", bus.flush, exp_flush);
      end
      tests++;
      if (count !== CW'(mdl.size())) begin
         fails++;
         $display("FAIL count: got %0d, required %0d", count, mdl.size());
      end
      tests++;
      if (bus.redirect_pc !== exp_redirect) begin
         fails++;
         $display("FAIL redirect_pc: got %h, required %h", bus.redirect_pc, exp_redirect);
      end
      tests++;
      if (underflow_err !== exp_uf) begin
         fails++;
         $display("FAIL underflow_err: got %b, required %b", underflow_err, exp_uf);
      end
   endtask

   task automatic idle();
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                       input logic [1:0] c);
      drive_cycle(1'b1, pc, t, tg, c, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic resolve(input logic t, input logic [31:0] tg);
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1, t, tg);
   endtask

   task automatic test_reset();
      bus.push_valid = 0; bus.push_pc = 0; bus.push_taken = 0; bus.push_target = 0;
      bus.push_ctr = 0; bus.resolve_valid = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.push_ready !== 1'b1 || count !== '0 || bus.upd_valid !== 1'b0 ||
          bus.flush !== 1'b0 || bus.redirect_pc !== 32'd0 || underflow_err !== 1'b0 ||
          bus.upd_index !== '0 || bus.upd_ctr !== 2'd0) begin
         fails++;
         $display("FAIL reset_values: got rdy=%b cnt=%0d uv=%b fl=%b rp=%h uf=%b ui=%h uc=%0d, required 1,0,0,0,0,0,0,0",
                  bus.push_ready, count, bus.upd_valid, bus.flush, bus.redirect_pc,
                  underflow_err, bus.upd_index, bus.upd_ctr);
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_basic();
      push(32'h100, 1'b1, 32'h200, 2'd2);
      resolve(1'b1, 32'h200);
      tests++;
      if (bus.upd_index !== 10'h040 || bus.upd_ctr !== 2'd3) begin
         fails++;
         $display("FAIL basic_update: got idx=%h ctr=%0d, required idx=040 ctr=3",
                  bus.upd_index, bus.upd_ctr);
      end
      idle();
   endtask

   task automatic test_saturation();
      push(32'h180, 1'b1, 32'h1c0, 2'd3);
      resolve(1'b1, 32'h1c0);
      tests++;
      if (bus.upd_ctr !== 2'd3) begin
         fails++;
         $display("FAIL sat_high: got %0d, required 3", bus.upd_ctr);
      end
      push(32'h1a0, 1'b0, 32'h0, 2'd0);
      resolve(1'b0, 32'h0);
      tests++;
      if (bus.upd_ctr !== 2'd0) begin
         fails++;
         $display("FAIL sat_low: got %0d, required 0", bus.upd_ctr);
      end
      idle();
   endtask

   task automatic test_full_mispredict();
      push(32'h300, 1'b1, 32'h380, 2'd2);
      push(32'h310, 1'b0, 32'h0,   2'd1);
      push(32'h320, 1'b1, 32'h3a0, 2'd3);
      push(32'h330, 1'b0, 32'h0,   2'd0);
      tests++;
      if (bus.push_ready !== 1'b0 || count !== CW'(4)) begin
         fails++;
         $display("FAIL full_state: got rdy=%b cnt=%0d, required rdy=0 cnt=4",
                  bus.push_ready, count);
      end
      drive_cycle(1'b1, 32'h340, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0);
      tests++;
      if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h304 || bus.upd_ctr !== 2'd1 ||
          count !== '0) begin
         fails++;
         $display("FAIL full_kill: got fl=%b rp=%h ctr=%0d cnt=%0d, required 1 304 1 0",
                  bus.flush, bus.redirect_pc, bus.upd_ctr, count);
      end
      idle();
      idle();
   endtask

   task automatic test_target_mispredict();
      push(32'h480, 1'b1, 32'h500, 2'd1);
      push(32'h490, 1'b0, 32'h0,   2'd2);
      // push_ready is 1 here; the offered push must still be dropped.
      drive_cycle(1'b1, 32'h4a0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 32'h540);
      tests++;
      if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h540 || count !== '0) begin
         fails++;
         $display("FAIL target_kill: got fl=%b rp=%h cnt=%0d, required 1 540 0",
                  bus.flush, bus.redirect_pc, count);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      logic        t;
      pc = 32'h1000;
      for (int i = 0; i < DEPTH; i++) begin
         t = 1'($urandom_range(0, 1));
         push(pc, t, pc + 32'h80, 2'($urandom_range(0, 3)));
         pc = pc + 32'h14;
      end
      for (int i = 0; i < 12; i++) begin
         t = 1'($urandom_range(0, 1));
         drive_cycle(1'b1, pc, t, pc + 32'h80, 2'($urandom_range(0, 3)),
                     1'b1, mdl[0].taken, mdl[0].taken ? mdl[0].target : 32'h0);
         pc = pc + 32'h14;
         tests++;
         if (count !== CW'(DEPTH - 1) && count !== CW'(DEPTH)) begin
            fails++;
            $display("FAIL stream_count: got %0d, required %0d or %0d", count, DEPTH - 1, DEPTH);
         end
      end
      while (mdl.size() > 0)
         resolve(mdl[0].taken, mdl[0].taken ? mdl[0].target : 32'h0);
      idle();
   endtask

   task automatic test_underflow_and_reset();
      resolve(1'b1, 32'h0);
      tests++;
      if (underflow_err !== 1'b1 || bus.upd_valid !== 1'b0) begin
         fails++;
         $display("FAIL underflow: got uf=%b uv=%b, required uf=1 uv=0",
                  underflow_err, bus.upd_valid);
      end
      drive_cycle(1'b1, 32'h800, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0);
      push(32'h810, 1'b1, 32'h900, 2'd2);
      push(32'h820, 1'b0, 32'h0,   2'd3);
      push(32'h830, 1'b0, 32'h0,   2'd1);
      resolve(1'b0, 32'h0);
      // A write-back strobe is live now; reset must cancel it at once.
      #1;
      rst = 1'b1;
      mdl.delete();
      exp_q.delete();
      exp_upd = 1'b0; exp_flush = 1'b0; exp_redirect = 32'd0; exp_uf = 1'b0;
      #1;
      tests++;
      if (count !== '0 || underflow_err !== 1'b0 || bus.upd_valid !== 1'b0 ||
          bus.push_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_reset: got cnt=%0d uf=%b uv=%b rdy=%b, required 0 0 0 1",
                  count, underflow_err, bus.upd_valid, bus.push_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) idle();
      resolve(1'b1, 32'h0);
      idle();
   endtask

   // Test sequence and report.
   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_full_mispredict();
      test_target_mispredict();
      test_back_to_back();
      test_underflow_and_reset();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Holds in-flight branch predictions between fetch and execute, and retires them in program order. The fetch stage pushes one entry per predicted branch: PC, predicted direction, predicted target and the 2-bit counter read from the branch history table. When execute resolves the oldest branch, the block computes the saturated counter write-back for the history table. On a misprediction it also issues a one-cycle flush with the corrected fetch PC and discards all younger entries.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- INDEX_BITS, 10, history-table index width; index = pc[INDEX_BITS+1:2]
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  = !full, combinational
- push_pc  in  32  branch instruction PC
- push_taken  in  1  predicted direction
- push_target  in  32  predicted target; don't-care when not taken
- push_ctr  in  2  counter value used for the prediction
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual target
- upd_valid  out  1  history-table write strobe, registered
- upd_index  out  INDEX_BITS  history-table write index, registered
- upd_ctr  out  2  new counter value, registered
- flush  out  1  mispredict pulse, registered
- redirect_pc  out  32  corrected fetch PC, valid while flush=1
- count  out  $clog2(DEPTH)+1  occupied entries
- underflow_err  out  1  sticky; set by a resolve when empty

## Operation
- Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH, plus a separate count register. full = (count==DEPTH).
- Push is accepted when push_valid && push_ready && no kill this cycle. The entry is written at wr_ptr, then wr_ptr increments.
- Resolve when count>0:
  - Head entry h is popped.
  - Counter update: resolve_taken ? min(h.ctr+1, 3) : max(h.ctr−1, 0), evaluated in 2-bit saturating arithmetic. 3 stays 3 on taken; 0 stays 0 on not-taken.
  - upd_valid=1, upd_index=h.pc[INDEX_BITS+1:2], upd_ctr=new value; all registered at the next edge.
  - Mispredict = (h.taken != resolve_taken) || (resolve_taken && h.target != resolve_target).
- Resolve when count==0: ignored, no update and no flush; underflow_err is set to 1 and holds until rst.
- Mispredict ("kill"), all at the same edge:
  - flush=1 for exactly one cycle.
  - redirect_pc = resolve_taken ? resolve_target : h.pc+4, with 32-bit wraparound.
  - count←0, rd_ptr←wr_ptr, so every younger entry is discarded.
  - A push in the same cycle is dropped even though push_ready was 1.
- Correct prediction: flush stays 0 and redirect_pc holds its previous value.
- Simultaneous push and resolve without kill: both take effect and count is unchanged. When full, push_ready=0 even if a resolve is present (no same-cycle bypass).
- Push and resolve on an empty queue in the same cycle: the resolve takes the underflow path; the push is accepted and count becomes 1.

## Timing
- Reset values: upd_valid=0, upd_index=0, upd_ctr=0, flush=0, redirect_pc=0, count=0, underflow_err=0, pointers=0. push_ready=1 during and after reset.
- Resolve to upd_valid/flush latency: 1 cycle. upd_valid and flush are single-cycle pulses unless resolves arrive back to back.
- Throughput: one push and one resolve per cycle.
- Entries are visible for resolve from the cycle after they are pushed.
- count and push_ready reflect the state after the last edge.
- Asserting rst mid-operation:
  - All entries are lost immediately.
  - Any pending upd_valid or flush pulse is cancelled.
  - No update is issued for entries that were queued.

## Test plan
- Reset, then push pc=0x100, taken=1, target=0x200, ctr=2, then resolve taken=1, target=0x200: next cycle upd_valid=1, upd_index=0x040, upd_ctr=3, flush=0, count=0.
- Push ctr=3, resolve taken → upd_ctr=3; push ctr=0, resolve not-taken → upd_ctr=0. Confirms saturation at both ends.
- Push 4 entries, with the head pc=0x300 predicted taken: push_ready=0 and count=4. Resolve the head not-taken → flush=1, redirect_pc=0x304, upd_ctr=head ctr−1. Next cycle count=0; a push offered in the resolve cycle is dropped.
- Push predicted taken to target 0x500, resolve taken with target 0x540 → flush=1, redirect_pc=0x540.
- Fill the queue and hold push_valid while resolving every cycle for 12 cycles with no mispredicts. Checks: in-order upd_index sequence, pointer wraparound, count steady at DEPTH−1 or DEPTH.
- Resolve on an empty queue → no upd_valid, underflow_err=1 held. Then assert rst mid-stream with 3 entries queued → count=0, underflow_err=0, no upd_valid after release.
